// File: rtl/lag_select_pkg.sv
// ============================================================================
// Module   : lag_select_pkg
// Brief    : Shared types and helpers for the LAG blocked-status selector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lag_select_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 16;
    localparam int ONEHOT_MAX_W         = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        STARVED = 2'd2
    } state_t;

    // True when exactly one of the low 'width' bits of vec is set.
    function automatic logic onehot(input logic [ONEHOT_MAX_W-1:0] vec, input int width);
        int n;
        n = 0;
        for (int i = 0; i < ONEHOT_MAX_W; i++) begin
            if (i < width && vec[i]) n++;
        end
        return (n == 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lag_onehot_chk.sv
// ============================================================================
// Module   : lag_onehot_chk
// Brief    : Combinational one-hot check of a W-bit select vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lag_onehot_chk
    import lag_select_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] vec,
    output logic         is_onehot
);

    logic [ONEHOT_MAX_W-1:0] w_ext;

    assign w_ext     = ONEHOT_MAX_W'(vec);
    assign is_onehot = onehot(w_ext, W);

endmodule

`default_nettype wire

// File: rtl/lag_blocked_select.sv
// ============================================================================
// Module   : lag_blocked_select
// Brief    : Registered blocked-flag selector with starvation and select checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lag_blocked_select
    import lag_select_pkg::*;
#(
    parameter int              INPUT_PORT   = 0,
    parameter int              WA           = 5,
    parameter int              WB           = 4,
    parameter logic [WA-1:0]   TURN_MASK    = '1,
    parameter int              STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int              CW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [WA-1:0]      sel_a,
    input  logic [WB-1:0]      sel_b,
    input  logic [WA*WB-1:0]   data_in,
    input  logic               grant,
    input  logic               err_clr,
    output logic               blocked,
    output logic               blocked_valid,
    output logic [CW-1:0]      blocked_cnt,
    output logic               starve,
    output logic               sel_err
);

    localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    logic               w_hit;
    logic               w_blk_now;
    logic               w_same;
    logic               w_release;
    logic               w_a_onehot;
    logic               w_b_onehot;
    logic               w_sel_bad;
    logic [WA+WB-1:0]   w_cur_sel;
    logic [CW-1:0]      w_cnt_inc;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_blocked;
    logic               r_blocked_valid;
    logic               r_prev_valid;
    logic [WA+WB-1:0]   r_last_sel;
    logic               r_sel_err;

    lag_onehot_chk #(.W(WA)) u_chk_a (
        .vec       (sel_a),
        .is_onehot (w_a_onehot)
    );

    lag_onehot_chk #(.W(WB)) u_chk_b (
        .vec       (sel_b),
        .is_onehot (w_b_onehot)
    );

    // Illegal turns are masked here, so they can never report blocked.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < WA; i++) begin
            for (int j = 0; j < WB; j++) begin
                w_hit = w_hit | (TURN_MASK[i] & sel_a[i] & sel_b[j] & data_in[i*WB+j]);
            end
        end
    end

    assign w_blk_now = req_valid & w_hit;
    assign w_cur_sel = {sel_a, sel_b};
    assign w_same    = req_valid & r_prev_valid & (w_cur_sel == r_last_sel);
    assign w_release = grant | ~w_blk_now;
    assign w_cnt_inc = r_cnt + C_ONE;
    assign w_sel_bad = req_valid & (~w_a_onehot | ~w_b_onehot | ((sel_a & ~TURN_MASK) != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_blocked       <= 1'b0;
            r_blocked_valid <= 1'b0;
            r_prev_valid    <= 1'b0;
            r_last_sel      <= '0;
            r_sel_err       <= 1'b0;
        end else begin
            r_blocked       <= w_blk_now;
            r_blocked_valid <= req_valid;
            r_prev_valid    <= req_valid;
            if (req_valid) r_last_sel <= w_cur_sel;

            // A new malformed select outranks a simultaneous clear.
            if (w_sel_bad)    r_sel_err <= 1'b1;
            else if (err_clr) r_sel_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_blk_now && !grant) begin
                        r_state <= WAIT;
                        r_cnt   <= C_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                WAIT, STARVED: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (!w_same) begin
                        r_state <= WAIT;
                        r_cnt   <= C_ONE;
                    end else if (r_state == WAIT) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == C_LIMIT) r_state <= STARVED;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    a_cnt_bounded: assert property (@(posedge clk) r_cnt <= C_LIMIT)
        else $error("lag_blocked_select[%0d]: blocked_cnt above limit", INPUT_PORT);

    assign blocked       = r_blocked;
    assign blocked_valid = r_blocked_valid;
    assign blocked_cnt   = r_cnt;
    assign starve        = (r_state == STARVED);
    assign sel_err       = r_sel_err;

endmodule

`default_nettype wire

// File: tb/tb_lag_blocked_select.sv
// ============================================================================
// Module   : tb_lag_blocked_select
// Brief    : Vector table, directed corner sequences and randomized model check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lag_blocked_select;

    localparam int            WA    = 5;
    localparam int            WB    = 4;
    localparam int            LIMIT = 4;
    localparam int            CW    = $clog2(LIMIT + 1);
    localparam logic [WA-1:0] MASK  = 5'b11101;
    localparam logic [19:0]   D_ALL = 20'hFFFFF;
    localparam logic [19:0]   D9    = 20'h00200;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic [WA-1:0]      sel_a = '0;
    logic [WB-1:0]      sel_b = '0;
    logic [WA*WB-1:0]   data_in = '0;
    logic               grant = 1'b0;
    logic               err_clr = 1'b0;
    logic               blocked;
    logic               blocked_valid;
    logic [CW-1:0]      blocked_cnt;
    logic               starve;
    logic               sel_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lag_blocked_select #(
        .INPUT_PORT   (0),
        .WA           (WA),
        .WB           (WB),
        .TURN_MASK    (MASK),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .sel_a         (sel_a),
        .sel_b         (sel_b),
        .data_in       (data_in),
        .grant         (grant),
        .err_clr       (err_clr),
        .blocked       (blocked),
        .blocked_valid (blocked_valid),
        .blocked_cnt   (blocked_cnt),
        .starve        (starve),
        .sel_err       (sel_err)
    );

    typedef struct {
        logic        rv;
        logic [4:0]  a;
        logic [3:0]  b;
        logic [19:0] d;
        logic        g;
        logic        c;
        logic        eb;
        logic        ev;
        int          ecnt;
        logic        es;
        logic        ee;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rv, logic [4:0] a, logic [3:0] b, logic [19:0] d,
                                logic g, logic c, logic eb, logic ev, int ecnt,
                                logic es, logic ee);
        vec_t v;
        v.rv = rv; v.a = a; v.b = b; v.d = d; v.g = g; v.c = c;
        v.eb = eb; v.ev = ev; v.ecnt = ecnt; v.es = es; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic r, input logic rv, input logic [4:0] a,
                        input logic [3:0] b, input logic [19:0] d,
                        input logic g, input logic c);
        rst = r; req_valid = rv; sel_a = a; sel_b = b; data_in = d;
        grant = g; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int eb, input int ev,
                             input int ecnt, input int es, input int ee);
        check({tag, ".blocked"},       int'(blocked),       eb);
        check({tag, ".blocked_valid"}, int'(blocked_valid), ev);
        check({tag, ".blocked_cnt"},   int'(blocked_cnt),   ecnt);
        check({tag, ".starve"},        int'(starve),        es);
        check({tag, ".sel_err"},       int'(sel_err),       ee);
    endtask

    // Reference model state: run length of the same blocked request.
    int          m_cnt;
    logic        m_blocked, m_bvalid, m_err, m_prev_valid;
    logic [8:0]  m_prev_sel;

    function automatic logic model_hit(logic [4:0] a, logic [3:0] b, logic [19:0] d);
        for (int k = 0; k < WA*WB; k++) begin
            if (d[k] && a[k / WB] && b[k % WB] && MASK[k / WB]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step(input logic r, input logic rv, input logic [4:0] a,
                              input logic [3:0] b, input logic [19:0] d,
                              input logic g, input logic c);
        logic blk, same_req, bad;
        if (r) begin
            m_cnt = 0; m_blocked = 0; m_bvalid = 0; m_err = 0;
            m_prev_valid = 0; m_prev_sel = '0;
        end else begin
            blk      = rv && model_hit(a, b, d);
            same_req = rv && m_prev_valid && ({a, b} == m_prev_sel);
            if (blk && !g) m_cnt = (m_cnt > 0 && same_req) ? ((m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1) : 1;
            else           m_cnt = 0;
            bad = rv && ($countones(a) != 1 || $countones(b) != 1 || (a & ~MASK) != 0);
            if (bad)    m_err = 1'b1;
            else if (c) m_err = 1'b0;
            m_blocked    = blk;
            m_bvalid     = rv;
            m_prev_valid = rv;
            if (rv) m_prev_sel = {a, b};
        end
    endtask

    initial begin
        logic [4:0]  ra;
        logic [3:0]  rb;
        logic [19:0] rd;
        logic        rrv, rg, rc, rr;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 5'($urandom), 4'($urandom), 20'($urandom), 1'($urandom), 1'($urandom));
            check_all("reset", 0, 0, 0, 0, 0);
        end
        step(1'b0, 1'b0, 5'b00001, 4'b0001, '0, 1'b0, 1'b0);
        check("post_reset.idle_valid", int'(blocked_valid), 0);
        step(1'b0, 1'b1, 5'b00001, 4'b0001, '0, 1'b0, 1'b0);
        check("post_reset.first_valid", int'(blocked_valid), 1);
        check("post_reset.first_blocked", int'(blocked), 0);
        step(1'b0, 1'b0, 5'b00001, 4'b0001, '0, 1'b0, 1'b0);

        //      rv  sel_a     sel_b    data   g  c   eb ev cnt st er
        vt.push_back(mk(1, 5'b00100, 4'b0010, D9,    0, 0,  1, 1, 1, 0, 0));
        vt.push_back(mk(1, 5'b00100, 4'b0010, '0,    0, 0,  0, 1, 0, 0, 0));
        vt.push_back(mk(1, 5'b00010, 4'b0010, D_ALL, 0, 0,  0, 1, 0, 0, 1));
        vt.push_back(mk(0, 5'b00100, 4'b0010, '0,    0, 1,  0, 0, 0, 0, 0));
        vt.push_back(mk(1, 5'b00010, 4'b0001, D_ALL, 0, 1,  0, 1, 0, 0, 1));
        vt.push_back(mk(0, 5'b00010, 4'b0001, D_ALL, 0, 1,  0, 0, 0, 0, 0));
        vt.push_back(mk(1, 5'b01000, 4'b0100, D_ALL, 0, 0,  1, 1, 1, 0, 0));
        vt.push_back(mk(1, 5'b01000, 4'b0100, D_ALL, 0, 0,  1, 1, 2, 0, 0));
        vt.push_back(mk(1, 5'b01000, 4'b0100, D_ALL, 0, 0,  1, 1, 3, 0, 0));
        vt.push_back(mk(1, 5'b01000, 4'b0100, D_ALL, 0, 0,  1, 1, 4, 1, 0));
        vt.push_back(mk(1, 5'b01000, 4'b0100, D_ALL, 0, 0,  1, 1, 4, 1, 0));
        vt.push_back(mk(1, 5'b01000, 4'b0100, D_ALL, 0, 0,  1, 1, 4, 1, 0));
        vt.push_back(mk(1, 5'b01000, 4'b0100, D_ALL, 1, 0,  1, 1, 0, 0, 0));
        vt.push_back(mk(1, 5'b00001, 4'b0001, D_ALL, 0, 0,  1, 1, 1, 0, 0));
        vt.push_back(mk(1, 5'b00001, 4'b0001, D_ALL, 0, 0,  1, 1, 2, 0, 0));
        vt.push_back(mk(1, 5'b00001, 4'b0001, D_ALL, 0, 0,  1, 1, 3, 0, 0));
        vt.push_back(mk(1, 5'b00100, 4'b0010, D_ALL, 0, 0,  1, 1, 1, 0, 0));
        vt.push_back(mk(0, 5'b00100, 4'b0010, D_ALL, 0, 0,  0, 0, 0, 0, 0));
        vt.push_back(mk(1, 5'b00100, 4'b0110, D_ALL, 0, 0,  1, 1, 1, 0, 1));
        vt.push_back(mk(0, 5'b00100, 4'b0110, D_ALL, 0, 1,  0, 0, 0, 0, 0));
        vt.push_back(mk(0, 5'b00100, 4'b0110, D_ALL, 0, 0,  0, 0, 0, 0, 0));
        vt.push_back(mk(1, 5'b00100, 4'b0110, D_ALL, 0, 0,  1, 1, 1, 0, 1));
        vt.push_back(mk(0, 5'b00100, 4'b0110, D_ALL, 0, 0,  0, 0, 0, 0, 1));
        vt.push_back(mk(0, 5'b00100, 4'b0110, D_ALL, 0, 1,  0, 0, 0, 0, 0));
        vt.push_back(mk(1, 5'b00000, 4'b0001, D_ALL, 0, 0,  0, 1, 0, 0, 1));
        vt.push_back(mk(0, 5'b00000, 4'b0001, D_ALL, 0, 1,  0, 0, 0, 0, 0));

        foreach (vt[i]) begin
            step(1'b0, vt[i].rv, vt[i].a, vt[i].b, vt[i].d, vt[i].g, vt[i].c);
            check_all($sformatf("vec%0d", i), vt[i].eb, vt[i].ev, vt[i].ecnt, vt[i].es, vt[i].ee);
        end

        // Starved request whose selection changes restarts at 1.
        for (int i = 1; i <= LIMIT; i++) begin
            step(1'b0, 1'b1, 5'b00001, 4'b1000, D_ALL, 1'b0, 1'b0);
            check($sformatf("starve_chg.cnt%0d", i), int'(blocked_cnt), i);
        end
        check("starve_chg.starved", int'(starve), 1);
        step(1'b0, 1'b1, 5'b10000, 4'b1000, D_ALL, 1'b0, 1'b0);
        check_all("starve_chg.switch", 1, 1, 1, 0, 0);

        // Reset while starved clears everything, even with an illegal select present.
        for (int i = 0; i < LIMIT; i++) step(1'b0, 1'b1, 5'b10000, 4'b1000, D_ALL, 1'b0, 1'b0);
        check("mid_reset.pre_starve", int'(starve), 1);
        step(1'b1, 1'b1, 5'b00010, 4'b1000, D_ALL, 1'b0, 1'b0);
        check_all("mid_reset", 0, 0, 0, 0, 0);

        // Randomized run against the reference model.
        model_step(1'b1, 0, '0, '0, '0, 0, 0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        ra = 5'b00001; rb = 4'b0001;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) < 20) begin
                ra = ($urandom_range(9) < 8) ? (5'b00001 << $urandom_range(4)) : 5'($urandom);
                rb = ($urandom_range(9) < 8) ? (4'b0001 << $urandom_range(3)) : 4'($urandom);
            end
            rd  = ($urandom_range(9) < 8) ? 20'($urandom | $urandom) : 20'($urandom & $urandom);
            rrv = ($urandom_range(99) < 90);
            rg  = ($urandom_range(99) < 8);
            rc  = ($urandom_range(99) < 10);
            rr  = ($urandom_range(999) < 5);
            model_step(rr, rrv, ra, rb, rd, rg, rc);
            step(rr, rrv, ra, rb, rd, rg, rc);
            check("rnd.blocked_valid", int'(blocked_valid), int'(m_bvalid));
            if (m_bvalid) check("rnd.blocked", int'(blocked), int'(m_blocked));
            check("rnd.blocked_cnt", int'(blocked_cnt), m_cnt);
            check("rnd.starve", int'(starve), int'(m_cnt == LIMIT));
            check("rnd.sel_err", int'(sel_err), int'(m_err));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
